jtag_scan_sequencer: RTL and testbench
======================================

# jtag_scan_sequencer

- Drives TMS and TDI for one complete JTAG scan per request: load an instruction into IR, then shift a DR pattern of programmable length, then return to Run-Test-Idle.
- Sits directly upstream of the TDI pattern generator and the TDO monitor.
  - Pulses `load` so the generator captures its scan pattern.
  - Muxes IR bits and generator bits onto TDI.
  - Raises `strobe` around Exit1-DR so the monitor compares expected against captured data.
- Keeps an internal mirror of the IEEE 1149.1 TAP state, so its own state always equals the TAP controller's state.

## Interface
- `IR_SIZE`, default 4: instruction register length in bits.
- `LEN_W`, default 8: width of the DR length field. The maximum DR scan is 2^LEN_W−1 bits.
- `TCK` input 1: test clock. All state changes on posedge.
- `TRST_N` input 1: asynchronous active-low reset.
- `start` input 1: request a scan. Sampled only when the mirror state is RTI and `busy`=0.
- `ir_code` input IR_SIZE: instruction, shifted LSB first. Latched on the accepting edge.
- `dr_length` input LEN_W: DR bits to shift. Latched on the accepting edge. 0 means skip the DR scan.
- `gen_tdi` input 1: bit 0 of the TDI generator shift register.
- `TMS` output 1: to TAP.
- `TDI` output 1: to TAP.
- `load` output 1: to the generator's `load`.
- `strobe` output 1: to the monitor's `strobe`.
- `busy` output 1: a scan is in progress.
- `done` output 1: one-cycle pulse when a scan ends.
- `tap_state` output 4: mirror state code, for debug. Encoding is IEEE 1149.1 numbering, with TLR = 4'hF.

## Operation
- **Mirror FSM.** Standard 16-state TAP graph, advanced on each posedge using the current TMS.
- **Output derivation.** TMS is a combinational function of the mirror state, the pass bit and the bit counter. It is stable across each posedge.
- **Reset.**
  - Mirror state = TLR; counter = 0; pass = IR.
  - TMS=0, TDI=0, load=0, strobe=0, busy=0, done=0.
- **Leaving TLR.** TLR with no job drives TMS=0, so the mirror enters RTI on the first edge after reset release.
- **Accept.** In RTI with `start`=1:
  - Latch `ir_code` into `ir_sh` and `dr_length` into `len`.
  - Set `busy`; drive TMS=1.
- **TMS per state:**
  - RTI (job active): 1.
  - Select-DR, pass IR: 1.
  - Select-IR: 0.
  - Capture-IR: 0.
  - Shift-IR: 0, except 1 on bit IR_SIZE−1.
  - Exit1-IR: 1.
  - Update-IR: 1 if `len`≠0, else 0.
  - Select-DR, pass DR: 0.
  - Capture-DR: 0.
  - Shift-DR: 0, except 1 on bit `len`−1.
  - Exit1-DR: 1.
  - Update-DR: 0.
- **Bit counter.** Counts shift cycles within Shift-IR and Shift-DR and clears on entry to each.
- **IR shift.** `ir_sh` shifts right one bit per Shift-IR cycle.
- **TDI mux:**
  - `ir_sh[0]` in Shift-IR.
  - `gen_tdi` in Shift-DR.
  - 0 in every other state.
- **load.** 1 in Capture-DR only.
- **strobe.** 1 in Exit1-DR and Update-DR.
- **done.** 1 in the RTI cycle reached from Update-DR or Update-IR. `busy` clears in that same cycle.
- **Start while busy.** Ignored; never queued.
- **Start held high.** A new scan is accepted in the `done` cycle.
- **TRST_N low mid-scan.** Immediate return to reset values; the latched job is discarded.

## Timing
- Accept edge = edge E0 (mirror in RTI, `start`=1).
- Shift-IR occupies cycles 4 … IR_SIZE+3 after E0.
- DR scan case (`len`≥1):
  - Capture-DR (`load`=1) at cycle IR_SIZE+7.
  - Shift-DR occupies IR_SIZE+8 … IR_SIZE+len+7.
  - `strobe` high for 2 cycles.
  - `done` at cycle IR_SIZE+len+10.
- `len`=0 case: Update-IR goes directly to RTI; `done` at cycle IR_SIZE+6; `load` and `strobe` never assert.
- `busy` rises on the cycle after E0 and is low in the `done` cycle.

## Configuration
- `JTAG_SEQ_RESET_EN` defined:
  - Each accepted scan first drives TMS=1 for 5 cycles (RTI → Select-DR → Select-IR → TLR → TLR → TLR).
  - Then TMS=0 for one cycle back to RTI, then the normal sequence.
  - All timing above shifts by +6 cycles.
- `JTAG_SEQ_RESET_EN` undefined: no TLR preamble; the sequence starts immediately from RTI.

## Test plan
- **Basic scan.** Reset; IR_SIZE=4, `ir_code`=4'b1010, `dr_length`=8, pulse `start` → TDI in Shift-IR = 0,1,0,1; `load` at cycle 11; 8 Shift-DR cycles follow `gen_tdi`; `strobe` 2 cycles; `done` at cycle 22; `tap_state` returns to RTI.
- **Zero-length DR.** `dr_length`=0 → Update-IR→RTI, `done` at cycle 10, `load` and `strobe` never high.
- **Single-bit DR.** `dr_length`=1 → Shift-DR lasts 1 cycle with TMS=1; `done` at cycle 15.
- **Start during scan.** Assert `start` mid-Shift-DR with new `ir_code` → ignored. Hold `start` high → second scan accepted in the `done` cycle, with back-to-back `busy`.
- **Reset mid-operation.** Drop TRST_N during Shift-IR → all outputs 0 and `tap_state`=TLR. After release → RTI one cycle later; next `start` accepted.
- **Preamble.** With `JTAG_SEQ_RESET_EN` defined → 5 TMS=1 cycles then one TMS=0 before Select-DR; `done` at cycle 28 for IR=4, DR=8.

Source files
------------

// File: rtl/jtag_scan_sequencer.sv
// rtl/jtag_scan_sequencer.sv - one IR+DR JTAG scan per request, with a TAP state mirror; JTAG_SEQ_RESET_EN adds a TLR preamble
module jtag_scan_sequencer #(
    parameter int IR_SIZE = 4,
    parameter int LEN_W   = 8
) (
    input  logic               TCK,
    input  logic               TRST_N,
    input  logic               start,
    input  logic [IR_SIZE-1:0] ir_code,
    input  logic [LEN_W-1:0]   dr_length,
    input  logic               gen_tdi,
    output logic               TMS,
    output logic               TDI,
    output logic               load,
    output logic               strobe,
    output logic               busy,
    output logic               done,
    output logic [3:0]         tap_state
);

    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RTI        = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TLR        = 4'hF
    } tap_t;

    localparam int IRW   = $clog2(IR_SIZE + 1);
    localparam int CNT_W = ((LEN_W > IRW) ? LEN_W : IRW) + 1;

`ifdef JTAG_SEQ_RESET_EN
    localparam logic PREAMBLE = 1'b1;
`else
    localparam logic PREAMBLE = 1'b0;
`endif

    tap_t               state;
    tap_t               nxt;
    logic               tms;
    logic               accept;
    logic               finish;
    logic               pass_dr;
    logic               pre;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   ir_last;
    logic [CNT_W-1:0]   len_last;
    logic [IR_SIZE-1:0] ir_sh;
    logic [LEN_W-1:0]   len;

    function automatic tap_t next_tap(input tap_t s, input logic m);
        case (s)
            TLR:        next_tap = m ? TLR       : RTI;
            RTI:        next_tap = m ? SELECT_DR : RTI;
            SELECT_DR:  next_tap = m ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: next_tap = m ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   next_tap = m ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   next_tap = m ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   next_tap = m ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   next_tap = m ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  next_tap = m ? SELECT_DR : RTI;
            SELECT_IR:  next_tap = m ? TLR       : CAPTURE_IR;
            CAPTURE_IR: next_tap = m ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   next_tap = m ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   next_tap = m ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   next_tap = m ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   next_tap = m ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  next_tap = m ? SELECT_DR : RTI;
            default:    next_tap = TLR;
        endcase
    endfunction

    assign ir_last  = CNT_W'(IR_SIZE - 1);
    assign len_last = CNT_W'(len) - CNT_W'(1);

    // TMS must be valid before the accepting edge, so start feeds it directly in idle RTI
    always_comb begin
        tms = 1'b0;
        case (state)
            TLR:        tms = busy && pre && (cnt < CNT_W'(2));
            RTI:        tms = busy || start;
            SELECT_DR:  tms = busy && (pre || !pass_dr);
            SELECT_IR:  tms = busy && pre;
            SHIFT_IR:   tms = (cnt == ir_last);
            EXIT1_IR:   tms = 1'b1;
            UPDATE_IR:  tms = (len != '0);
            SHIFT_DR:   tms = (cnt == len_last);
            EXIT1_DR:   tms = 1'b1;
            PAUSE_DR, EXIT2_DR, PAUSE_IR, EXIT2_IR: tms = 1'b1;
            default:    tms = 1'b0;
        endcase
    end

    always_comb begin
        TDI = 1'b0;
        if (state == SHIFT_IR) begin
            TDI = ir_sh[0];
        end else if (state == SHIFT_DR) begin
            TDI = gen_tdi;
        end
    end

    assign nxt       = next_tap(state, tms);
    assign accept    = (state == RTI) && !busy && start;
    assign finish    = busy && !tms && ((state == UPDATE_DR) || (state == UPDATE_IR));
    assign TMS       = tms;
    assign tap_state = state;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state   <= TLR;
            cnt     <= '0;
            pass_dr <= 1'b0;
            pre     <= 1'b0;
            ir_sh   <= '0;
            len     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            load    <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            state  <= nxt;
            load   <= (nxt == CAPTURE_DR);
            strobe <= (nxt == EXIT1_DR) || (nxt == UPDATE_DR);
            done   <= 1'b0;

            // cnt doubles as the TLR dwell counter during the preamble
            case (state)
                SHIFT_IR: begin
                    cnt   <= cnt + CNT_W'(1);
                    ir_sh <= ir_sh >> 1;
                end
                SHIFT_DR: cnt <= cnt + CNT_W'(1);
                TLR:      if (busy) cnt <= cnt + CNT_W'(1);
                default:  cnt <= '0;
            endcase

            if (accept) begin
                busy    <= 1'b1;
                ir_sh   <= ir_code;
                len     <= dr_length;
                pass_dr <= 1'b0;
                pre     <= PREAMBLE;
            end

            if ((state == TLR) && !tms) begin
                pre <= 1'b0;
            end

            if (state == UPDATE_IR) begin
                pass_dr <= tms;
            end

            if (finish) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                pass_dr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb/tb_jtag_scan_sequencer.sv - randomized bench for jtag_scan_sequencer against a scan-timeline model
module tb_jtag_scan_sequencer;

    localparam int IR_SIZE = 4;
    localparam int LEN_W   = 8;
`ifdef JTAG_SEQ_RESET_EN
    localparam int PRE = 6;
`else
    localparam int PRE = 0;
`endif

    localparam logic [3:0] S_EXIT1_DR   = 4'h1;
    localparam logic [3:0] S_SHIFT_DR   = 4'h2;
    localparam logic [3:0] S_SELECT_IR  = 4'h4;
    localparam logic [3:0] S_UPDATE_DR  = 4'h5;
    localparam logic [3:0] S_CAPTURE_DR = 4'h6;
    localparam logic [3:0] S_SELECT_DR  = 4'h7;
    localparam logic [3:0] S_EXIT1_IR   = 4'h9;
    localparam logic [3:0] S_SHIFT_IR   = 4'hA;
    localparam logic [3:0] S_RTI        = 4'hC;
    localparam logic [3:0] S_UPDATE_IR  = 4'hD;
    localparam logic [3:0] S_CAPTURE_IR = 4'hE;
    localparam logic [3:0] S_TLR        = 4'hF;

    logic               TCK = 1'b0;
    logic               TRST_N = 1'b0;
    logic               start = 1'b0;
    logic [IR_SIZE-1:0] ir_code = '0;
    logic [LEN_W-1:0]   dr_length = '0;
    logic               gen_tdi = 1'b0;
    logic               TMS;
    logic               TDI;
    logic               load;
    logic               strobe;
    logic               busy;
    logic               done;
    logic [3:0]         tap_state;

    int checks = 0;
    int errors = 0;

    jtag_scan_sequencer #(.IR_SIZE(IR_SIZE), .LEN_W(LEN_W)) dut (
        .TCK(TCK), .TRST_N(TRST_N), .start(start), .ir_code(ir_code),
        .dr_length(dr_length), .gen_tdi(gen_tdi), .TMS(TMS), .TDI(TDI),
        .load(load), .strobe(strobe), .busy(busy), .done(done), .tap_state(tap_state)
    );

    always #5 TCK = ~TCK;

    // In the TAP graph, a step into these states is always taken with TMS=1
    function automatic bit tms_into(input logic [3:0] s);
        return (s == S_SELECT_DR) || (s == S_SELECT_IR) || (s == S_TLR) ||
               (s == S_EXIT1_IR) || (s == S_EXIT1_DR) ||
               (s == S_UPDATE_IR) || (s == S_UPDATE_DR);
    endfunction

    task automatic run_scan(input logic [3:0] ir, input int len, input bit chained,
                            input bit mid_start, input bit nxt_valid,
                            input logic [3:0] nxt_ir, input int nxt_len);
        logic [3:0] q[$];
        logic [3:0] st;
        int d;
        int irbit;
        bit exp_tms;
        bit exp_tdi;
        bit mid_done;
        q.push_back(S_RTI);
        if (PRE != 0) begin
            q.push_back(S_SELECT_DR);
            q.push_back(S_SELECT_IR);
            repeat (3) q.push_back(S_TLR);
            q.push_back(S_RTI);
        end
        q.push_back(S_SELECT_DR);
        q.push_back(S_SELECT_IR);
        q.push_back(S_CAPTURE_IR);
        repeat (IR_SIZE) q.push_back(S_SHIFT_IR);
        q.push_back(S_EXIT1_IR);
        q.push_back(S_UPDATE_IR);
        if (len != 0) begin
            q.push_back(S_SELECT_DR);
            q.push_back(S_CAPTURE_DR);
            repeat (len) q.push_back(S_SHIFT_DR);
            q.push_back(S_EXIT1_DR);
            q.push_back(S_UPDATE_DR);
        end
        q.push_back(S_RTI);
        d = q.size() - 1;
        if (!chained) begin
            start = 1'b1;
            ir_code = ir;
            dr_length = 8'(len);
        end
        irbit = 0;
        mid_done = 1'b0;
        for (int n = (chained ? 1 : 0); n <= d; n++) begin
            @(negedge TCK);
            st = q[n];
            exp_tms = (n < d) ? tms_into(q[n+1]) : nxt_valid;
            exp_tdi = 1'b0;
            if (st == S_SHIFT_IR) begin
                exp_tdi = ir[irbit];
                irbit++;
            end else if (st == S_SHIFT_DR) begin
                exp_tdi = gen_tdi;
            end
            checks++;
            if (tap_state !== st) begin
                errors++;
                $display("FAIL scan_state: cycle %0d got %h expected %h (ir=%h len=%0d)", n, tap_state, st, ir, len);
            end
            checks++;
            if (TMS !== exp_tms) begin
                errors++;
                $display("FAIL scan_tms: cycle %0d got %b expected %b (ir=%h len=%0d)", n, TMS, exp_tms, ir, len);
            end
            checks++;
            if (TDI !== exp_tdi) begin
                errors++;
                $display("FAIL scan_tdi: cycle %0d got %b expected %b (ir=%h len=%0d)", n, TDI, exp_tdi, ir, len);
            end
            checks++;
            if (load !== (st == S_CAPTURE_DR)) begin
                errors++;
                $display("FAIL scan_load: cycle %0d got %b expected %b (len=%0d)", n, load, (st == S_CAPTURE_DR), len);
            end
            checks++;
            if (strobe !== ((st == S_EXIT1_DR) || (st == S_UPDATE_DR))) begin
                errors++;
                $display("FAIL scan_strobe: cycle %0d got %b expected %b (len=%0d)", n, strobe,
                         ((st == S_EXIT1_DR) || (st == S_UPDATE_DR)), len);
            end
            checks++;
            if (busy !== ((n >= 1) && (n < d))) begin
                errors++;
                $display("FAIL scan_busy: cycle %0d got %b expected %b (len=%0d)", n, busy, ((n >= 1) && (n < d)), len);
            end
            checks++;
            if (done !== (n == d)) begin
                errors++;
                $display("FAIL scan_done: cycle %0d got %b expected %b (len=%0d)", n, done, (n == d), len);
            end
            @(posedge TCK);
            #1;
            gen_tdi = 1'($urandom);
            if (n + 1 == d) begin
                start = nxt_valid;
                ir_code = nxt_ir;
                dr_length = 8'(nxt_len);
            end else if (mid_start && !mid_done && (n < d) && (q[n+1] == S_SHIFT_DR)) begin
                start = 1'b1;
                ir_code = 4'($urandom);
                dr_length = 8'($urandom);
                mid_done = 1'b1;
            end else begin
                start = 1'b0;
                ir_code = 4'($urandom);
                dr_length = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        TRST_N = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge TCK);
        checks++;
        if ({TMS, TDI, load, strobe, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", {TMS, TDI, load, strobe, busy, done});
        end
        checks++;
        if (tap_state !== S_TLR) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", tap_state, S_TLR);
        end
        @(posedge TCK);
        #1;
        TRST_N = 1'b1;
        start = 1'b1;
        @(negedge TCK);
        checks++;
        if ((tap_state !== S_TLR) || (TMS !== 1'b0) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL release_tlr: got state=%h tms=%b busy=%b expected F 0 0", tap_state, TMS, busy);
        end
        @(posedge TCK);
        #1;
        start = 1'b0;
        @(negedge TCK);
        checks++;
        if ((tap_state !== S_RTI) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL release_rti: got state=%h busy=%b expected C 0", tap_state, busy);
        end
        @(posedge TCK);
        #1;
    endtask

    task automatic test_basic();
        run_scan(4'b1010, 8, 1'b0, 1'b0, 1'b0, 4'h0, 0);
    endtask

    task automatic test_zero_len();
        run_scan(4'($urandom), 0, 1'b0, 1'b0, 1'b0, 4'h0, 0);
    endtask

    task automatic test_single_bit();
        run_scan(4'($urandom), 1, 1'b0, 1'b0, 1'b0, 4'h0, 0);
    endtask

    task automatic test_start_during_scan();
        logic [3:0] ir2;
        int len2;
        ir2 = 4'($urandom);
        len2 = $urandom_range(1, 12);
        run_scan(4'($urandom), 10, 1'b0, 1'b1, 1'b1, ir2, len2);
        run_scan(ir2, len2, 1'b1, 1'b0, 1'b0, 4'h0, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] ir_a;
        logic [3:0] ir_b;
        int len_b;
        ir_a = 4'($urandom);
        ir_b = 4'($urandom);
        len_b = $urandom_range(1, 6);
        run_scan(4'($urandom), $urandom_range(1, 6), 1'b0, 1'b0, 1'b1, ir_a, 0);
        run_scan(ir_a, 0, 1'b1, 1'b0, 1'b1, ir_b, len_b);
        run_scan(ir_b, len_b, 1'b1, 1'b0, 1'b0, 4'h0, 0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        ir_code = 4'($urandom);
        dr_length = 8'd9;
        @(posedge TCK);
        #1;
        start = 1'b0;
        repeat (4 + PRE) @(posedge TCK);
        #2;
        checks++;
        if (tap_state !== S_SHIFT_IR) begin
            errors++;
            $display("FAIL mid_pre_state: got %h expected %h", tap_state, S_SHIFT_IR);
        end
        TRST_N = 1'b0;
        #1;
        checks++;
        if ({TMS, TDI, load, strobe, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b expected 000000", {TMS, TDI, load, strobe, busy, done});
        end
        checks++;
        if (tap_state !== S_TLR) begin
            errors++;
            $display("FAIL mid_reset_state: got %h expected %h", tap_state, S_TLR);
        end
        @(posedge TCK);
        #1;
        TRST_N = 1'b1;
        @(negedge TCK);
        checks++;
        if ((tap_state !== S_TLR) || (busy !== 1'b0) || (TMS !== 1'b0)) begin
            errors++;
            $display("FAIL mid_release_tlr: got state=%h busy=%b tms=%b expected F 0 0", tap_state, busy, TMS);
        end
        @(posedge TCK);
        #1;
        @(negedge TCK);
        checks++;
        if ((tap_state !== S_RTI) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL mid_release_rti: got state=%h busy=%b expected C 0", tap_state, busy);
        end
        @(posedge TCK);
        #1;
        run_scan(4'($urandom), $urandom_range(0, 5), 1'b0, 1'b0, 1'b0, 4'h0, 0);
    endtask

    task automatic test_random();
        logic [3:0] ir_n;
        int len_n;
        bit chain;
        logic [3:0] ir_c;
        int len_c;
        chain = 1'b0;
        ir_c = 4'($urandom);
        len_c = $urandom_range(0, 20);
        for (int i = 0; i < 8; i++) begin
            ir_n = 4'($urandom);
            len_n = (i == 7) ? 255 : $urandom_range(0, 20);
            if (i < 7 && $urandom_range(0, 1) == 1) begin
                run_scan(ir_c, len_c, chain, 1'($urandom), 1'b1, ir_n, len_n);
                chain = 1'b1;
            end else begin
                run_scan(ir_c, len_c, chain, 1'($urandom), 1'b0, 4'h0, 0);
                chain = 1'b0;
            end
            ir_c = ir_n;
            len_c = len_n;
        end
        run_scan(ir_c, len_c, chain, 1'b0, 1'b0, 4'h0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_single_bit();
        test_start_during_scan();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
